coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
Front-end stage that sits directly upstream of vending_mealy. It converts the raw, asynchronous, bouncy coin-slot sensor levels into clean one-cycle coin codes on the 2-bit coin bus that the vending FSM consumes. It synchronizes and debounces each sensor and rejects ambiguous or inhibited insertions. It also guarantees an idle (00) gap between codes, so no coin is ever counted twice.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a press, and also to accept a release; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
n_sense  input  1  raw 5-unit sensor level, asynchronous to clk
d_sense  input  1  raw 10-unit sensor level, asynchronous to clk
inhibit  input  1  synchronous; when high, accepted coins are returned rather than credited
coin  output  2  to vending_mealy: 00 none, 01 five, 10 ten; never 11; one-cycle pulses
reject  output  1  one-cycle pulse: coin returned (ambiguous or inhibited)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): coin=00, reject=0, busy=0, state=IDLE, counter=0, synchronizer flops=0. Release of reset is synchronous to clk.
- Synchronizers: two flops per sensor; the FSM sees only the synchronized values ns and ds. Latency is 2 cycles.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.
- FSM states: IDLE, QUAL, EMIT, REJ, WAIT_REL. Outputs are registered and decoded from the state.
- IDLE:
  - exactly one of ns/ds high -> QUAL; latch the type (five or ten); cnt=1.
  - both high -> REJ.
  - neither high -> stay in IDLE.
- QUAL, on each edge:
  - latched sensor still high and the other sensor low: if cnt==DEBOUNCE_CYCLES -> EMIT, else cnt++.
  - latched sensor low -> IDLE, no output (glitch filtered).
  - other sensor high -> REJ.
- EMIT (exactly one cycle):
  - inhibit=0: coin = 01 or 10 per the latched type.
  - inhibit=1: coin=00 and reject=1 instead.
  - next state -> WAIT_REL with cnt=0.
- REJ (exactly one cycle): reject=1, coin=00; next state -> WAIT_REL with cnt=0.
- WAIT_REL:
  - ns=0 and ds=0: cnt++; when cnt==DEBOUNCE_CYCLES -> IDLE.
  - any sensor high: cnt=0.
  - coin stays 00 throughout.
- Latency: take edge 0 as the first edge that samples a raw sensor high, with the sensor held clean for DEBOUNCE_CYCLES+1 samples. The coin pulse is then visible in the cycle after edge DEBOUNCE_CYCLES+2 (cycle after edge 6 for the default).
- Separation: between any two non-00 coin pulses there are at least DEBOUNCE_CYCLES+2 cycles of 00.
- At most one pulse (coin or reject) per physical insertion; coin and reject are never high together.
- inhibit is sampled only in EMIT. An inhibit change during QUAL or WAIT_REL has no effect.
- Reset mid-operation: outputs return to their reset values immediately, and any partially qualified coin is discarded. After release, a sensor that is still held high is treated as a new insertion.
- A sensor held high indefinitely produces one pulse only; the FSM waits in WAIT_REL.

Decomposition:
- Shared package (vending_pkg):
  - coin code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10, also used by vending_mealy.
  - the coin_acceptor state encoding.
- Sub-module sync_2ff (1-bit, asynchronous active-low reset to 0), instantiated once per sensor.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Clean five: n_sense high for 10 cycles, then low -> exactly one coin=01 pulse, in the cycle after edge 6; then busy stays high until 4 low synchronized samples have been seen.
- Bouncy ten: d_sense toggling 1,0,1,1,0,1 and then steady high for 8 cycles -> exactly one coin=10 pulse; no pulse during the bounce; reject=0 throughout.
- Glitch: n_sense high for 3 cycles, then low -> no coin, no reject; FSM returns to IDLE.
- Both sensors: n_sense and d_sense rising together, or d_sense rising during n_sense qualification -> single reject pulse, coin stays 00.
- Inhibit: inhibit=1 throughout a clean ten insertion -> reject=1 for one cycle, coin=00. Inhibit=0 on the next insertion -> coin=10.
- Reset mid-qualification: rst=0 at edge 4 of a five insertion -> coin=00, busy=0 immediately; after rst=1 with the sensor released, no pulse. Drive the chain 10,10 / 5,5,10 / 10,10,5 through this block into vending_mealy -> the dispense and chg5 sequence matches direct coin-bus drive.

Source files
------------

// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending front end and the vending FSM:
//   - coin bus codes driven by coin_acceptor and consumed by vending_mealy
//   - coin_acceptor state encoding
//   - coin_code(): maps the latched coin type onto the coin bus
// -----------------------------------------------------------------------------
package vending_pkg;

    // Coin bus codes. 2'b11 is never driven.
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // coin_acceptor states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_QUAL     = 3'd1;
    localparam logic [2:0] ST_EMIT     = 3'd2;
    localparam logic [2:0] ST_REJ      = 3'd3;
    localparam logic [2:0] ST_WAIT_REL = 3'd4;

    function automatic logic [1:0] coin_code(input logic is_ten);
        return is_ten ? COIN_10 : COIN_5;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for one asynchronous level input.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears both flops to 0
//   i_d    : asynchronous input level
//   o_q    : synchronized level, two clk cycles behind i_d
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
// Turns raw, bouncy coin-slot sensor levels into clean one-cycle coin codes for
// vending_mealy. Each sensor is synchronized and debounced; ambiguous (both
// sensors) or inhibited insertions are returned with a reject pulse. After any
// pulse the block waits for a debounced release before arming again, so one
// physical insertion yields at most one pulse.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   n_sense  : raw 5-unit sensor level (asynchronous)
//   d_sense  : raw 10-unit sensor level (asynchronous)
//   inhibit  : synchronous; looked at only in EMIT, turns the coin into a reject
//   coin     : 00 none, 01 five, 10 ten; one-cycle pulses
//   reject   : one-cycle pulse, coin returned
//   busy     : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4   // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       n_sense,
    input  logic       d_sense,
    input  logic       inhibit,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          w_ns;
    logic          w_ds;
    logic          w_mine;
    logic          w_other;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_is_ten;

    logic [2:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_is_ten_nxt;

    sync_2ff u_sync_n (.clk(clk), .rst_n(rst), .i_d(n_sense), .o_q(w_ns));
    sync_2ff u_sync_d (.clk(clk), .rst_n(rst), .i_d(d_sense), .o_q(w_ds));

    // Sensor of the latched coin type, and the one that must stay quiet.
    assign w_mine  = r_is_ten ? w_ds : w_ns;
    assign w_other = r_is_ten ? w_ns : w_ds;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_ten_nxt = r_is_ten;

        case (r_state)
            ST_IDLE: begin
                if (w_ns ^ w_ds) begin
                    w_state_nxt  = ST_QUAL;
                    w_is_ten_nxt = w_ds;
                    w_cnt_nxt    = CNT_ONE;
                end else if (w_ns && w_ds) begin
                    w_state_nxt = ST_REJ;
                end
            end

            ST_QUAL: begin
                if (!w_mine) begin
                    // Dropped before qualifying: a glitch, discard silently.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_other) begin
                    w_state_nxt = ST_REJ;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            ST_EMIT, ST_REJ: begin
                w_state_nxt = ST_WAIT_REL;
                w_cnt_nxt   = '0;
            end

            ST_WAIT_REL: begin
                if (w_ns || w_ds) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    // This edge sees the last required low sample.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_ten <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_ten <= w_is_ten_nxt;
        end
    end

    // Outputs decode the registered state only (plus inhibit, which matters
    // only during EMIT), so each pulse lasts exactly the one EMIT/REJ cycle and
    // everything drops to idle values the instant reset is asserted.
    assign coin   = (r_state == ST_EMIT && !inhibit) ? coin_code(r_is_ten) : COIN_NONE;
    assign reject = (r_state == ST_REJ) || (r_state == ST_EMIT && inhibit);
    assign busy   = (r_state != ST_IDLE);

endmodule
